// File: rtl/dbus_arbiter_pkg.sv
// Shared data-bus types: transfer encodings plus the arbiter's state and owner enums.
package dbus_arbiter_pkg;

    typedef enum logic {
        READ  = 1'b0,
        WRITE = 1'b1
    } ttype_t;

    typedef enum logic [1:0] {
        BYTE     = 2'b00,
        HALFWORD = 2'b01,
        WORD     = 2'b10
    } tsize_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    typedef enum logic {
        OWNER_CORE = 1'b0,
        OWNER_DM   = 1'b1
    } arb_owner_t;

    localparam int ARB_CNT_W = 8;

endpackage

// File: rtl/dbus_arbiter.sv
// Two-master arbiter (core D-bus / debug SBA) in front of the interconnect's single
// master port: one transaction in flight, response routed back, hung-slave timeout.
module dbus_arbiter
    import dbus_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT     = 255,
    parameter bit          DM_PRIORITY = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        halted,

    input  logic        c_req,
    input  logic [31:0] c_addr,
    input  logic        c_ttype,
    input  logic [1:0]  c_tsize,
    input  logic [31:0] c_wdata,
    output logic [31:0] c_rdata,
    output logic        c_done,
    output logic        c_err,

    input  logic        d_req,
    input  logic [31:0] d_addr,
    input  logic        d_ttype,
    input  logic [1:0]  d_tsize,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_done,
    output logic        d_err,

    output logic        s_bstart,
    output logic [31:0] s_addr,
    output logic        s_ttype,
    output logic [1:0]  s_tsize,
    output logic [31:0] s_wdata,
    input  logic [31:0] s_rdata,
    input  logic        s_done,

    output logic        owner
);

    localparam logic [ARB_CNT_W-1:0] LP_TIMEOUT = ARB_CNT_W'(TIMEOUT);

    arb_state_t             r_state;
    arb_owner_t             r_owner;
    logic [ARB_CNT_W-1:0]   r_cnt;
    logic [31:0]            r_s_addr;
    logic                   r_s_ttype;
    logic [1:0]             r_s_tsize;
    logic [31:0]            r_s_wdata;
    logic [31:0]            r_c_rdata;
    logic                   r_c_err;
    logic [31:0]            r_d_rdata;
    logic                   r_d_err;

    logic                   w_any_req;
    logic                   w_grant_dm;

    // A contested grant goes to the DM while halted (if enabled), else to whoever did not go last.
    assign w_any_req  = c_req | d_req;
    assign w_grant_dm = d_req & (~c_req | (DM_PRIORITY & halted) | (r_owner == OWNER_CORE));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_owner   <= OWNER_CORE;
            r_cnt     <= '0;
            r_s_addr  <= '0;
            r_s_ttype <= 1'b0;
            r_s_tsize <= '0;
            r_s_wdata <= '0;
            r_c_rdata <= '0;
            r_c_err   <= 1'b0;
            r_d_rdata <= '0;
            r_d_err   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any_req) begin
                        r_owner   <= w_grant_dm ? OWNER_DM : OWNER_CORE;
                        r_s_addr  <= w_grant_dm ? d_addr  : c_addr;
                        r_s_ttype <= w_grant_dm ? d_ttype : c_ttype;
                        r_s_tsize <= w_grant_dm ? d_tsize : c_tsize;
                        r_s_wdata <= w_grant_dm ? d_wdata : c_wdata;
                        r_state   <= ISSUE;
                    end
                end
                ISSUE: begin
                    r_cnt   <= '0;
                    r_state <= WAIT;
                end
                WAIT: begin
                    if (s_done) begin
                        if (r_owner == OWNER_DM) begin
                            r_d_rdata <= s_rdata;
                            r_d_err   <= 1'b0;
                        end else begin
                            r_c_rdata <= s_rdata;
                            r_c_err   <= 1'b0;
                        end
                        r_state <= RESP;
                    end else if (r_cnt == LP_TIMEOUT) begin
                        if (r_owner == OWNER_DM) begin
                            r_d_rdata <= '0;
                            r_d_err   <= 1'b1;
                        end else begin
                            r_c_rdata <= '0;
                            r_c_err   <= 1'b1;
                        end
                        r_state <= RESP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                RESP: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign s_bstart = (r_state == ISSUE);
    assign c_done   = (r_state == RESP) && (r_owner == OWNER_CORE);
    assign d_done   = (r_state == RESP) && (r_owner == OWNER_DM);
    assign s_addr   = r_s_addr;
    assign s_ttype  = r_s_ttype;
    assign s_tsize  = r_s_tsize;
    assign s_wdata  = r_s_wdata;
    assign c_rdata  = r_c_rdata;
    assign c_err    = r_c_err;
    assign d_rdata  = r_d_rdata;
    assign d_err    = r_d_err;
    assign owner    = r_owner;

endmodule

// File: tb/tb_dbus_arbiter.sv
// Directed bench for dbus_arbiter (TIMEOUT=8): each step drives inputs 1ns after the
// rising edge and checks hand-computed outputs at that same point.
module tb_dbus_arbiter;
    import dbus_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        halted;
    logic        c_req, c_ttype, c_done, c_err;
    logic [31:0] c_addr, c_wdata, c_rdata;
    logic [1:0]  c_tsize;
    logic        d_req, d_ttype, d_done, d_err;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic [1:0]  d_tsize;
    logic        s_bstart, s_ttype, s_done;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic [1:0]  s_tsize;
    logic        owner;

    int errors = 0;
    int checks = 0;

    dbus_arbiter #(.TIMEOUT(8), .DM_PRIORITY(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .halted(halted),
        .c_req(c_req), .c_addr(c_addr), .c_ttype(c_ttype), .c_tsize(c_tsize),
        .c_wdata(c_wdata), .c_rdata(c_rdata), .c_done(c_done), .c_err(c_err),
        .d_req(d_req), .d_addr(d_addr), .d_ttype(d_ttype), .d_tsize(d_tsize),
        .d_wdata(d_wdata), .d_rdata(d_rdata), .d_done(d_done), .d_err(d_err),
        .s_bstart(s_bstart), .s_addr(s_addr), .s_ttype(s_ttype), .s_tsize(s_tsize),
        .s_wdata(s_wdata), .s_rdata(s_rdata), .s_done(s_done),
        .owner(owner)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0; halted = 1'b0;
        c_req = 1'b0; c_addr = '0; c_ttype = READ; c_tsize = WORD; c_wdata = '0;
        d_req = 1'b0; d_addr = '0; d_ttype = READ; d_tsize = WORD; d_wdata = '0;
        s_done = 1'b0; s_rdata = '0;

        // reset values
        tick(); tick();
        chk("rst_bstart", 32'(s_bstart), 0);
        chk("rst_owner",  32'(owner), 0);
        chk("rst_cdone",  32'(c_done), 0);
        chk("rst_ddone",  32'(d_done), 0);
        chk("rst_saddr",  s_addr, 0);
        chk("rst_crdata", c_rdata, 0);
        rst_n = 1'b1;
        tick();

        // spurious s_done in IDLE
        s_done = 1'b1; s_rdata = 32'hDEADBEEF;
        tick();
        s_done = 1'b0;
        chk("spur_bstart", 32'(s_bstart), 0);
        chk("spur_cdone",  32'(c_done), 0);
        chk("spur_ddone",  32'(d_done), 0);
        chk("spur_crdata", c_rdata, 0);
        tick();
        chk("spur_bstart2", 32'(s_bstart), 0);
        chk("spur_cdone2",  32'(c_done), 0);

        // core-only read
        c_req = 1'b1; c_addr = 32'h3000000C; c_ttype = READ; c_tsize = WORD;
        tick();
        chk("cr_bstart", 32'(s_bstart), 1);
        chk("cr_saddr",  s_addr, 32'h3000000C);
        chk("cr_owner",  32'(owner), 0);
        tick();
        chk("cr_bstart_off", 32'(s_bstart), 0);
        chk("cr_cdone_early", 32'(c_done), 0);
        s_done = 1'b1; s_rdata = 32'h000000A5;
        tick();
        s_done = 1'b0; s_rdata = '0;
        chk("cr_cdone",  32'(c_done), 1);
        chk("cr_crdata", c_rdata, 32'h000000A5);
        chk("cr_cerr",   32'(c_err), 0);
        chk("cr_ddone",  32'(d_done), 0);
        c_req = 1'b0;
        tick();
        chk("cr_cdone_off", 32'(c_done), 0);
        chk("cr_idle_bstart", 32'(s_bstart), 0);

        // simultaneous requests while halted: DM first, then core
        halted = 1'b1;
        c_req = 1'b1; c_addr = 32'h10000000;
        d_req = 1'b1; d_addr = 32'h20000004;
        tick();
        chk("pr_owner1", 32'(owner), 1);
        chk("pr_saddr1", s_addr, 32'h20000004);
        chk("pr_bstart1", 32'(s_bstart), 1);
        tick();
        s_done = 1'b1; s_rdata = 32'h11112222;
        tick();
        s_done = 1'b0;
        chk("pr_ddone",  32'(d_done), 1);
        chk("pr_cdone0", 32'(c_done), 0);
        chk("pr_drdata", d_rdata, 32'h11112222);
        d_req = 1'b0;
        tick();
        chk("pr_idle_bstart", 32'(s_bstart), 0);
        tick();
        chk("pr_owner2", 32'(owner), 0);
        chk("pr_saddr2", s_addr, 32'h10000000);
        chk("pr_bstart2", 32'(s_bstart), 1);
        tick();
        s_done = 1'b1; s_rdata = 32'h33334444;
        tick();
        s_done = 1'b0;
        chk("pr_cdone",  32'(c_done), 1);
        chk("pr_crdata", c_rdata, 32'h33334444);
        c_req = 1'b0; halted = 1'b0;
        tick();

        // DM write, slave never answers: timeout 10 cycles after s_bstart
        d_req = 1'b1; d_addr = 32'h40000000; d_ttype = WRITE; d_tsize = HALFWORD; d_wdata = 32'hCAFEF00D;
        tick();
        chk("to_bstart", 32'(s_bstart), 1);
        chk("to_owner",  32'(owner), 1);
        chk("to_sttype", 32'(s_ttype), 1);
        chk("to_stsize", 32'(s_tsize), 32'(HALFWORD));
        chk("to_swdata", s_wdata, 32'hCAFEF00D);
        for (int k = 1; k < 10; k++) begin
            tick();
            chk($sformatf("to_wait%0d_ddone", k), 32'(d_done), 0);
        end
        tick();
        chk("to_ddone",  32'(d_done), 1);
        chk("to_derr",   32'(d_err), 1);
        chk("to_drdata", d_rdata, 0);
        chk("to_cdone",  32'(c_done), 0);
        d_req = 1'b0; d_ttype = READ; d_tsize = WORD;
        tick();
        chk("to_ddone_off", 32'(d_done), 0);
        chk("to_idle_bstart", 32'(s_bstart), 0);

        // both held, not halted: last owner was DM, so core/DM/core/DM
        c_req = 1'b1; c_addr = 32'h50000000;
        d_req = 1'b1; d_addr = 32'h60000000;
        for (int i = 0; i < 4; i++) begin
            logic exp_dm;
            exp_dm = (i % 2) == 1;
            tick();
            chk($sformatf("rr%0d_bstart", i), 32'(s_bstart), 1);
            chk($sformatf("rr%0d_owner", i), 32'(owner), 32'(exp_dm));
            tick();
            chk($sformatf("rr%0d_bstart_off", i), 32'(s_bstart), 0);
            s_done = 1'b1; s_rdata = 32'hA000_0000 + 32'(i);
            tick();
            s_done = 1'b0;
            chk($sformatf("rr%0d_cdone", i), 32'(c_done), 32'(!exp_dm));
            chk($sformatf("rr%0d_ddone", i), 32'(d_done), 32'(exp_dm));
            if (i == 3) begin
                c_req = 1'b0; d_req = 1'b0;
            end
            tick();
            chk($sformatf("rr%0d_idle_bstart", i), 32'(s_bstart), 0);
        end
        chk("rr_crdata", c_rdata, 32'hA0000002);
        chk("rr_drdata", d_rdata, 32'hA0000003);

        // asynchronous reset during WAIT of a DM read
        d_req = 1'b1; d_addr = 32'h70000000;
        tick();
        chk("ar_owner_pre", 32'(owner), 1);
        tick();
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk("ar_owner",  32'(owner), 0);
        chk("ar_saddr",  s_addr, 0);
        chk("ar_crdata", c_rdata, 0);
        chk("ar_drdata", d_rdata, 0);
        chk("ar_bstart", 32'(s_bstart), 0);
        d_req = 1'b0;
        tick();
        chk("ar_ddone", 32'(d_done), 0);
        rst_n = 1'b1;
        tick();
        chk("ar_ddone2", 32'(d_done), 0);

        // core request after reset completes normally
        c_req = 1'b1; c_addr = 32'h3000_0010;
        tick();
        chk("pa_bstart", 32'(s_bstart), 1);
        chk("pa_saddr",  s_addr, 32'h30000010);
        tick();
        s_done = 1'b1; s_rdata = 32'h5A5A5A5A;
        tick();
        s_done = 1'b0;
        chk("pa_cdone",  32'(c_done), 1);
        chk("pa_crdata", c_rdata, 32'h5A5A5A5A);
        chk("pa_cerr",   32'(c_err), 0);
        chk("pa_ddone",  32'(d_done), 0);
        c_req = 1'b0;
        tick();
        chk("pa_cdone_off", 32'(c_done), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
